// File: rtl/kgp_fetch_unit_pkg.sv
// Shared KGP-RISC constants for the fetch stage and controller: NOP encoding,
// default reset PC and instruction field positions.
package kgp_fetch_unit_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   function automatic logic [5:0] opcode_of(input logic [31:0] word);
      return word[OPCODE_MSB:OPCODE_LSB];
   endfunction

   function automatic logic [5:0] funct_of(input logic [31:0] word);
      return word[FUNCT_MSB:FUNCT_LSB];
   endfunction

endpackage

// File: rtl/kgp_fetch_unit_fifo.sv
// Fetch queue: small synchronous FIFO of {instr, pc} entries with a flush that
// overrides push and pop. The head is read straight from the entry registers.
module kgp_fetch_fifo
   import kgp_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int W     = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       flush,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          do_push;
   logic          do_pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign count   = count_reg;
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= wdata;
   end

   assign rdata = mem[rd_ptr_reg];

endmodule

// File: rtl/kgp_fetch_unit.sv
// KGP-RISC instruction fetch: owns the PC, issues one-cycle-latency imem reads,
// queues returned words and hands them to decode over valid/ready.
module kgp_fetch_unit
   import kgp_fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
   parameter int                PC_STEP  = 4,
   parameter int                DEPTH    = 2
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              pcsrc,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [31:0]       instr,
   output logic [ADDR_W-1:0] instr_pc
);

   localparam int W  = 32 + ADDR_W;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;

   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] req_pc_reg;
   logic              inflight_reg;
   logic              epoch_reg;
   logic              req_epoch_reg;

   logic              pop;
   logic              push;
   logic              issue;
   logic [SW-1:0]     occ_sum;
   logic [W-1:0]      head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;

   assign pop     = instr_valid && instr_ready;
   // Words already queued plus the one returning now, minus the one leaving now.
   assign occ_sum = SW'(fifo_count) + SW'(inflight_reg) - SW'(pop);
   assign issue   = !pcsrc && (occ_sum < SW'(DEPTH));

   // Gated by reset so the request drops the instant reset is asserted.
   assign imem_req  = issue && reset;
   assign imem_addr = pc_reg;

   // A response from before the last redirect carries a stale epoch and is dropped.
   assign push = imem_rvalid && inflight_reg && (req_epoch_reg == epoch_reg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg        <= RESET_PC;
         req_pc_reg    <= '0;
         inflight_reg  <= 1'b0;
         epoch_reg     <= 1'b0;
         req_epoch_reg <= 1'b0;
      end else begin
         inflight_reg <= issue;
         if (pcsrc) begin
            pc_reg    <= redirect_pc;
            epoch_reg <= ~epoch_reg;
         end else if (issue) begin
            pc_reg        <= pc_reg + ADDR_W'(PC_STEP);
            req_pc_reg    <= pc_reg;
            req_epoch_reg <= epoch_reg;
         end
      end
   end

   kgp_fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (pcsrc),
      .wdata ({imem_rdata, req_pc_reg}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign instr_valid = !fifo_empty;
   assign instr       = instr_valid ? head[W-1 -: 32] : NOP_INSTR;
   assign instr_pc    = instr_valid ? head[ADDR_W-1:0] : '0;

`ifndef SYNTHESIS
   a_rvalid_matched: assert property (@(posedge clk) disable iff (!reset)
      imem_rvalid |-> inflight_reg)
      else $error("imem_rvalid with no request in flight");

   a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
      !(push && fifo_full && !pop && !pcsrc))
      else $error("fetch queue overflow");
`endif

endmodule

// File: tb/tb_kgp_fetch_unit.sv
// Bench for kgp_fetch_unit: directed phases then random ready/redirect/reset,
// checked by an expected-PC scoreboard fed on reset and redirect.
module tb_kgp_fetch_unit;

   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata  = 32'h0;
   logic        pcsrc;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   logic        rst_w;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_rvalid = 1'b0;
   logic [31:0] w_rdata  = 32'h0;
   logic        w_pcsrc  = 1'b0;
   logic [31:0] w_redirect = 32'h0;
   logic        w_valid;
   logic        w_ready  = 1'b1;
   logic [31:0] w_instr;
   logic [31:0] w_pc;

   kgp_fetch_unit u_dut (
      .clk         (clk),
      .reset       (reset),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pcsrc       (pcsrc),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc)
   );

   kgp_fetch_unit #(.RESET_PC(WRAP_PC)) u_wrap (
      .clk         (clk),
      .reset       (rst_w),
      .imem_req    (w_req),
      .imem_addr   (w_addr),
      .imem_rvalid (w_rvalid),
      .imem_rdata  (w_rdata),
      .pcsrc       (w_pcsrc),
      .redirect_pc (w_redirect),
      .instr_valid (w_valid),
      .instr_ready (w_ready),
      .instr       (w_instr),
      .instr_pc    (w_pc)
   );

   // Instruction memory contents as a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   always @(posedge clk) begin
      imem_rvalid <= imem_req;
      imem_rdata  <= mem_word(imem_addr);
      w_rvalid    <= w_req;
      w_rdata     <= mem_word(w_addr);
   end

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int pops     = 0;
   int w_cnt    = 0;

   task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: decode must see consecutive words starting at the last
   // reset or redirect target; anything not yet accepted is thrown away.
   logic [31:0] exp_q[$];
   logic [31:0] next_pc;

   task automatic restart(input logic [31:0] start);
      exp_q.delete();
      next_pc = start;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(next_pc);
         next_pc = next_pc + 32'd4;
      end
   endtask

   logic [31:0] wrap_exp [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

   // Monitor: samples 1 time unit after each falling edge.
   initial begin
      logic        prev_reset = 1'b0;
      logic        prev_valid = 1'b0;
      logic        prev_ready = 1'b0;
      logic        prev_pcsrc = 1'b0;
      logic [31:0] prev_instr = 32'h0;
      logic [31:0] prev_pc    = 32'h0;
      logic        armed      = 1'b0;
      int          arm_cycle  = 0;
      int          arm_lat    = 0;
      logic [31:0] arm_pc     = 32'h0;
      int          stall_run  = 0;
      logic [31:0] e;
      restart(RST_PC);
      forever begin
         @(negedge clk);
         #1;
         cyc++;
         if (!reset) begin
            chk_eq("reset_instr_valid", 32'(instr_valid), 32'd0);
            chk_eq("reset_imem_req", 32'(imem_req), 32'd0);
            chk_eq("reset_instr", instr, 32'h0);
            chk_eq("reset_instr_pc", instr_pc, 32'h0);
            restart(RST_PC);
            armed     = 1'b0;
            stall_run = 0;
         end else begin
            if (!prev_reset) begin
               if (!pcsrc) begin
                  chk_eq("first_req", 32'(imem_req), 32'd1);
                  chk_eq("first_addr", imem_addr, RST_PC);
               end
               armed = 1'b1; arm_cycle = cyc; arm_lat = 2; arm_pc = RST_PC;
            end
            if (armed && cyc > arm_cycle && (instr_valid || cyc - arm_cycle >= arm_lat)) begin
               chk_eq("first_valid_latency", 32'(cyc - arm_cycle), 32'(arm_lat));
               if (instr_valid) chk_eq("first_valid_pc", instr_pc, arm_pc);
               armed = 1'b0;
            end
            if (prev_reset && prev_valid && !prev_ready && !prev_pcsrc) begin
               chk_eq("hold_valid", 32'(instr_valid), 32'd1);
               chk_eq("hold_instr", instr, prev_instr);
               chk_eq("hold_pc", instr_pc, prev_pc);
            end
            if (!instr_valid) chk_eq("empty_nop", instr, 32'h0);
            if (!instr_ready && !pcsrc) stall_run++;
            else stall_run = 0;
            if (stall_run >= 4) chk_eq("stall_no_req", 32'(imem_req), 32'd0);
            if (pcsrc) begin
               restart(redirect_pc);
               armed = 1'b1; arm_cycle = cyc; arm_lat = 3; arm_pc = redirect_pc;
            end else if (instr_valid && instr_ready) begin
               e = exp_q.pop_front();
               chk_eq("pop_pc", instr_pc, e);
               chk_eq("pop_instr", instr, mem_word(e));
               pops++;
               while (exp_q.size() < 4) begin
                  exp_q.push_back(next_pc);
                  next_pc = next_pc + 32'd4;
               end
            end
         end
         if (rst_w && w_valid && w_cnt < 4) begin
            chk_eq("wrap_pc", w_pc, wrap_exp[w_cnt]);
            chk_eq("wrap_instr", w_instr, mem_word(wrap_exp[w_cnt]));
            w_cnt++;
         end
         prev_reset = reset;
         prev_valid = instr_valid;
         prev_ready = instr_ready;
         prev_pcsrc = pcsrc;
         prev_instr = instr;
         prev_pc    = instr_pc;
      end
   end

   task automatic step(input logic r, input logic p, input logic [31:0] a);
      @(negedge clk);
      instr_ready = r;
      pcsrc       = p;
      redirect_pc = a;
   endtask

   // Driver: inputs change on falling edges only.
   initial begin
      int rst_left = 0;
      reset = 1'b0; rst_w = 1'b0;
      instr_ready = 1'b1; pcsrc = 1'b0; redirect_pc = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b1; rst_w = 1'b1;
      repeat (12) step(1'b1, 1'b0, 32'h0);
      // Decode stall then release.
      repeat (5) step(1'b0, 1'b0, 32'h0);
      repeat (8) step(1'b1, 1'b0, 32'h0);
      // Redirect right after a full-queue pop with a request in flight.
      repeat (2) step(1'b0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'h100);
      repeat (8) step(1'b1, 1'b0, 32'h0);
      // Back-to-back redirects; only the second target may reach decode.
      step(1'b1, 1'b1, 32'h40);
      step(1'b1, 1'b1, 32'h80);
      repeat (8) step(1'b1, 1'b0, 32'h0);
      // Reset mid-stream with a word queued.
      step(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      reset = 1'b0; instr_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) step(1'b1, 1'b0, 32'h0);
      // Random ready, redirects and occasional resets.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) reset = 1'b1;
         end else if ($urandom_range(0, 199) == 0) begin
            reset    = 1'b0;
            rst_left = 2;
         end
         instr_ready = ($urandom_range(0, 99) < 70);
         pcsrc       = ($urandom_range(0, 99) < 4);
         redirect_pc = $urandom & 32'hFFFF_FFFC;
      end
      reset = 1'b1;
      repeat (6) step(1'b1, 1'b0, 32'h0);
      chk_eq("throughput", 32'(pops >= 300), 32'd1);
      chk_eq("wrap_count", 32'(w_cnt), 32'd4);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
